// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the drink dispenser slice: dispenser FSM state
// encoding, default timing/stock constants and width helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPENSE = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_e;

   localparam int DEF_CHANNELS        = 4;
   localparam int DEF_PULSE_CYCLES    = 5;
   localparam int DEF_COOLDOWN_CYCLES = 3;
   localparam int DEF_STOCK_MAX       = 3;

   // Channel index width; a single-channel build still gets a 1-bit select.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width needed to hold the values 0..maxval.
   function automatic int cnt_width(input int maxval);
      return (maxval > 0) ? $clog2(maxval + 1) : 1;
   endfunction

endpackage

// File: rtl/drink_dispenser_stock_counter.sv
// -----------------------------------------------------------------------------
// stock_counter
// Per-channel stock register: saturating down-counter reloaded to STOCK_MAX
// by a refill strobe, with an empty flag decoded from the register.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset (stock returns to STOCK_MAX)
//   load_i  - refill this channel
//   dec_i   - consume one unit from this channel
//   empty_o - high while the stock register is zero
// -----------------------------------------------------------------------------
module stock_counter
   import vending_pkg::*;
#(
   parameter int STOCK_MAX = DEF_STOCK_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic empty_o
);

   localparam int SW = cnt_width(STOCK_MAX);

   logic [SW-1:0] stock_q;
   logic [SW-1:0] stock_d;

   // A refill coinciding with a consumption leaves one unit fewer than full.
   always_comb begin
      stock_d = stock_q;
      if (load_i && dec_i) begin
         stock_d = SW'(STOCK_MAX - 1);
      end else if (load_i) begin
         stock_d = SW'(STOCK_MAX);
      end else if (dec_i && (stock_q != '0)) begin
         stock_d = stock_q - SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stock_q <= SW'(STOCK_MAX);
      end else begin
         stock_q <= stock_d;
      end
   end

   assign empty_o = (stock_q == '0);

endmodule

// File: rtl/drink_dispenser.sv
// -----------------------------------------------------------------------------
// drink_dispenser
// Multi-channel dispense controller. Accepts a request for one drink line,
// drives that line's control output for PULSE_CYCLES cycles, pulses done,
// then holds off new requests for COOLDOWN_CYCLES cycles. Tracks stock per
// channel and rejects requests for empty or non-existent channels.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   req, req_ch   - dispense request and channel, sampled while ready=1
//   refill        - refill strobe for channel refill_ch (any state)
//   ready         - high in IDLE
//   busy          - high in DISPENSE or COOLDOWN
//   drink_contral - one-hot registered control lines
//   done          - one-cycle pulse on the first cycle after the pulse ends
//   err           - one-cycle pulse after a rejected request
//   empty         - per-channel stock-empty flags
// -----------------------------------------------------------------------------
module drink_dispenser
   import vending_pkg::*;
#(
   parameter int CHANNELS        = DEF_CHANNELS,
   parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter int STOCK_MAX       = DEF_STOCK_MAX,
   localparam int CH_W           = ch_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [CH_W-1:0]     req_ch,
   input  logic                refill,
   input  logic [CH_W-1:0]     refill_ch,
   output logic                ready,
   output logic                busy,
   output logic [CHANNELS-1:0] drink_contral,
   output logic                done,
   output logic                err,
   output logic [CHANNELS-1:0] empty
);

   localparam int TMR_MAX = (PULSE_CYCLES > COOLDOWN_CYCLES) ? PULSE_CYCLES : COOLDOWN_CYCLES;
   localparam int TMR_W   = cnt_width(TMR_MAX);
   localparam int CD_LOAD = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;

   state_e              state_q;
   logic [TMR_W-1:0]    tmr_q;
   logic [CHANNELS-1:0] ctrl_q;
   logic                done_q;
   logic                err_q;
   logic                ready_q;
   logic                busy_q;

   logic [CHANNELS-1:0] req_sel;
   logic [CHANNELS-1:0] refill_sel;
   logic [CHANNELS-1:0] empty_w;
   logic                req_stocked;
   logic                accept;
   logic                reject;

   // One-hot channel decode; an out-of-range channel decodes to all zeros,
   // which makes it look like an empty line and gets it rejected.
   always_comb begin
      req_sel    = '0;
      refill_sel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         req_sel[i]    = (req_ch == CH_W'(i));
         refill_sel[i] = (refill_ch == CH_W'(i));
      end
   end

   assign req_stocked = |(req_sel & ~empty_w);
   assign accept      = req && (state_q == ST_IDLE) && req_stocked;
   assign reject      = req && (state_q == ST_IDLE) && !req_stocked;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      stock_counter #(
         .STOCK_MAX (STOCK_MAX)
      ) u_stock (
         .clk     (clk),
         .rst     (rst),
         .load_i  (refill && refill_sel[g]),
         .dec_i   (accept && req_sel[g]),
         .empty_o (empty_w[g])
      );
   end

   // tmr_q holds the remaining cycles of the current phase minus one, so the
   // phase ends on the edge where it reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         ctrl_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_DISPENSE;
                  ctrl_q  <= req_sel;
                  tmr_q   <= TMR_W'(PULSE_CYCLES - 1);
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (reject) begin
                  err_q <= 1'b1;
               end
            end
            ST_DISPENSE: begin
               if (tmr_q == '0) begin
                  ctrl_q <= '0;
                  done_q <= 1'b1;
                  if (COOLDOWN_CYCLES == 0) begin
                     state_q <= ST_IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_COOLDOWN;
                     tmr_q   <= TMR_W'(CD_LOAD);
                  end
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
            end
            ST_COOLDOWN: begin
               if (tmr_q == '0) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ctrl_q  <= '0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready         = ready_q;
   assign busy          = busy_q;
   assign drink_contral = ctrl_q;
   assign done          = done_q;
   assign err           = err_q;
   assign empty         = empty_w;

endmodule
